axi4_rd_arbiter: RTL

AXI4_RD_ARBITER -- requirements
Module: axi4_rd_arbiter

---
 rtl/axi4_rd_arbiter_if.sv | 39 +++
 rtl/axi4_rd_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/axi4_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the requesters and the downstream port.
// host drives requests and rready; agent answers with aready and the R channel.
interface axi4_rd_intf #(
  parameter int DWIDTH  = 64,
  parameter int AWIDTH  = 32,
  parameter int IDWIDTH = 1
);
  logic               avalid;
  logic               aready;
  logic [IDWIDTH-1:0] aid;
  logic [AWIDTH-1:0]  aaddr;
  logic [7:0]         alen;
  logic [2:0]         asize;
  logic [1:0]         aburst;
  logic               alock;
  logic [3:0]         acache;
  logic [2:0]         aprot;
  logic [3:0]         aregion;
  logic [3:0]         aqos;

  logic               rvalid;
  logic               rready;
  logic [IDWIDTH-1:0] rid;
  logic [DWIDTH-1:0]  rdata;
  logic [1:0]         rresp;
  logic               rlast;

  modport host (
    output avalid, aid, aaddr, alen, asize, aburst, alock, acache, aprot, aregion, aqos,
    output rready,
    input  aready, rvalid, rid, rdata, rresp, rlast
  );

  modport agent (
    input  avalid, aid, aaddr, alen, asize, aburst, alock, acache, aprot, aregion, aqos,
    input  rready,
    output aready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi4_rd_arbiter.sv
// Two-requester AXI4 read arbiter with one outstanding transaction on the shared port.
// Define AXI4_RD_ARB_RR_EN for round-robin arbitration; otherwise s0 has fixed priority.
module axi4_rd_arbiter #(
  parameter int DWIDTH  = 64,
  parameter int AWIDTH  = 32,
  parameter int IDWIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  axi4_rd_intf.agent       s0,
  axi4_rd_intf.agent       s1,
  axi4_rd_intf.host        m,
  output logic [1:0]       gnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [IDWIDTH-1:0] id;
    logic [AWIDTH-1:0]  addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic               lock;
    logic [3:0]         cache;
    logic [2:0]         prot;
    logic [3:0]         region;
    logic [3:0]         qos;
  } ar_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  ar_t               ar_q, ar_d;
  ar_t               s0_ar, s1_ar;
  logic              sel1;
  logic              take;
  logic              in_data;
  logic [DWIDTH-1:0] rdata_fwd;

  assign s0_ar = '{id: s0.aid, addr: s0.aaddr, len: s0.alen, size: s0.asize, burst: s0.aburst,
                   lock: s0.alock, cache: s0.acache, prot: s0.aprot, region: s0.aregion, qos: s0.aqos};
  assign s1_ar = '{id: s1.aid, addr: s1.aaddr, len: s1.alen, size: s1.asize, burst: s1.aburst,
                   lock: s1.alock, cache: s1.acache, prot: s1.aprot, region: s1.aregion, qos: s1.aqos};

`ifdef AXI4_RD_ARB_RR_EN
  // prio_q=1 means s1 wins the next contention; flips to the loser after every grant.
  logic prio_q, prio_d;

  assign sel1 = s1.avalid && (!s0.avalid || prio_q);

  always_comb begin
    prio_d = prio_q;
    if (take) prio_d = !sel1;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end
`else
  assign sel1 = s1.avalid && !s0.avalid;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ar_d      = ar_q;
    take      = 1'b0;
    s0.aready = 1'b0;
    s1.aready = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0.avalid || s1.avalid) begin
          take      = 1'b1;
          s0.aready = !sel1;
          s1.aready = sel1;
          owner_d   = sel1;
          ar_d      = sel1 ? s1_ar : s0_ar;
          state_d   = ADDR;
        end
      end
      ADDR:    if (m.aready) state_d = DATA;
      DATA:    if (m.rvalid && m.rready && m.rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ar_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ar_q    <= ar_d;
    end
  end

  assign m.avalid  = (state_q == ADDR);
  assign m.aid     = ar_q.id;
  assign m.aaddr   = ar_q.addr;
  assign m.alen    = ar_q.len;
  assign m.asize   = ar_q.size;
  assign m.aburst  = ar_q.burst;
  assign m.alock   = ar_q.lock;
  assign m.acache  = ar_q.cache;
  assign m.aprot   = ar_q.prot;
  assign m.aregion = ar_q.region;
  assign m.aqos    = ar_q.qos;

  // R channel is forwarded with no register stage; only the owner sees rvalid.
  assign in_data   = (state_q == DATA);
  assign m.rready  = in_data && (owner_q ? s1.rready : s0.rready);
  assign s0.rvalid = in_data && !owner_q && m.rvalid;
  assign s1.rvalid = in_data &&  owner_q && m.rvalid;

  assign rdata_fwd = m.rdata;
  assign s0.rdata  = rdata_fwd;
  assign s1.rdata  = rdata_fwd;
  assign s0.rid    = m.rid;
  assign s1.rid    = m.rid;
  assign s0.rresp  = m.rresp;
  assign s1.rresp  = m.rresp;
  assign s0.rlast  = m.rlast;
  assign s1.rlast  = m.rlast;

  assign gnt  = (state_q == IDLE) ? 2'b00 : {owner_q, !owner_q};
  assign busy = (state_q != IDLE);

endmodule
